bram_rr_arbiter: RTL and testbench
==================================

// Module: bram_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one native BRAM port among NUM_REQ requesters.
//  Typical requesters: the PS GP0 AXI BRAM controller and PL traffic/LED engines.
//  One access is granted per cycle. The winner's access is registered onto the BRAM port.
//  A shift-register tag pipeline returns a response pulse to the originating requester.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8)
//  ADDR_W   32  byte-address width
//  DATA_W   32  data width (multiple of 8)
//  RD_LAT   1   BRAM read latency in cycles, from bram_en to bram_dout valid (1..3)
// PORTS
//  ACLK       in   1                clock, all logic on rising edge
//  ARESETn    in   1                asynchronous active-low reset
//  req_valid  in   NUM_REQ          per-requester access request
//  req_ready  out  NUM_REQ          grant; access accepted when valid&ready
//  req_we     in   NUM_REQ          1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_W   byte address, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W   write data, packed as req_addr
//  req_wstrb  in   NUM_REQ*DATA_W/8 byte enables, packed as req_addr
//  rsp_valid  out  NUM_REQ          one-cycle completion pulse to requester i (no backpressure)
//  rsp_rdata  out  DATA_W           read data, qualified by rsp_valid
//  grant_id   out  $clog2(NUM_REQ)  id of the last accepted requester
//  bram_en    out  1                BRAM enable
//  bram_we    out  DATA_W/8         BRAM byte write enables
//  bram_addr  out  ADDR_W           BRAM byte address
//  bram_din   out  DATA_W           BRAM write data
//  bram_dout  in   DATA_W           BRAM read data
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, bram_en=0, bram_we=0,
//    bram_addr=0, bram_din=0, grant_id=0, rr_last=NUM_REQ-1, tag pipeline cleared.
//  - Grant (combinational):
//    - Search req_valid starting at (rr_last+1) mod NUM_REQ, wrapping.
//    - The first asserted requester gets req_ready=1. At most one bit of req_ready is set.
//    - req_ready is 0 for any requester with req_valid=0.
//  - Accept cycle T (valid&ready):
//    - rr_last <= winner and grant_id <= winner.
//    - At T+1: bram_en=1, bram_addr=req_addr with low log2(DATA_W/8) bits zeroed,
//      bram_din=req_wdata.
//    - bram_we = req_we ? req_wstrb : 0.
//  - No request at T: bram_en=0 and bram_we=0 at T+1; rr_last is unchanged.
//  - Tag pipeline, depth RD_LAT+1: each stage holds {valid, id, is_read}.
//  - Response timing for an access accepted at T: rsp_valid[id] pulses at T+1+RD_LAT.
//    - Read: rsp_rdata=bram_dout, sampled in that cycle.
//    - Write: rsp_rdata=0.
//  - Throughput: one access per cycle sustained, fully pipelined.
//  - A single active requester is granted every cycle.
//  - All requesters active: grants rotate 0,1,..,N-1,0,...
//  - Simultaneous events:
//    - A new request and an issuing response in the same cycle are independent.
//    - A requester may receive rsp_valid and req_ready in the same cycle.
//  - Read-after-write: when the same address is accepted on consecutive cycles,
//    the read returns the written data, because BRAM port ordering is preserved.
//  - Reset mid-operation: in-flight tags are discarded and no rsp_valid is emitted
//    for them. The BRAM port is idled asynchronously.
//  - No request reordering. Responses return in acceptance order.
// STRUCTURE
//  - bram_arb_pkg: clog2 helper, tag struct width constant, ADDR_LSB = log2(DATA_W/8).
//  - Sub-module rr_grant: combinational rotate-priority encoder.
//    - Inputs: valid vector and rr_last.
//    - Outputs: one-hot grant and binary id.
//  - Top level: input mux, BRAM port registers, tag shift register, response demux.
// TESTING
//  1. Reset: hold ARESETn=0 for 20 ACLK, release.
//     -> All outputs 0. First lone req_valid[0] is granted the same cycle.
//  2. Write then read, RD_LAT=1, requester 0:
//     - Write 0xA0010000/0xDEADBEEF/wstrb=F.
//     - Read the same address on the next cycle.
//     -> bram_we=F at T+1.
//     -> Write rsp at T+2.
//     -> Read rsp at T+3 with rsp_rdata=0xDEADBEEF.
//  3. Both requesters valid for 8 cycles (reads):
//     -> Grants alternate 0,1,0,1...
//     -> rsp_valid pulses alternate, each RD_LAT+1 cycles after its grant.
//  4. Byte strobes: write 0xFFFFFFFF, then write 0x00000000 with wstrb=4'b0101.
//     -> Readback 0xFF00FF00.
//  5. Reset mid-burst: assert ARESETn=0 one cycle after 3 reads are accepted.
//     -> No rsp_valid after reset.
//     -> rr_last restarts so requester 0 is granted first.
//  6. RD_LAT=3 sweep with NUM_REQ=4, random valids, 1000 cycles.
//     -> Scoreboard confirms in-order responses, correct ids, no lost or duplicated grants.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the round-robin BRAM port arbiter.
// Tags carry enough id bits for the largest supported requester count (8).
package bram_arb_pkg;

  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                is_read;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotate-priority encoder: searches i_valid starting just after
// i_last, wrapping, and returns the first hit as one-hot grant plus binary id.
module rr_grant #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((32'(i_last) + k) % NUM_REQ);
      if (!w_found && i_valid[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_id           = w_idx;
      end
    end
  end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one native BRAM port among NUM_REQ requesters,
// with a tag shift register that routes each completion back to its requester.
module bram_rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         bram_en,
  output logic [DATA_W/8-1:0]          bram_we,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic [DATA_W-1:0]            bram_din,
  input  logic [DATA_W-1:0]            bram_dout
);

  localparam int unsigned ID_W     = clog2(NUM_REQ);
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << ADDR_LSB) - ADDR_W'(1));

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_id;
  logic               w_accept;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [STRB_W-1:0]  w_sel_wstrb;
  tag_t               w_tag_in;
  tag_t               w_tag_out;

  logic               r_bram_en;
  logic [STRB_W-1:0]  r_bram_we;
  logic [ADDR_W-1:0]  r_bram_addr;
  logic [DATA_W-1:0]  r_bram_din;
  logic [ID_W-1:0]    r_rr_last;
  logic [ID_W-1:0]    r_grant_id;
  tag_t [RD_LAT:0]    r_tag;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .i_valid (req_valid),
    .i_last  (r_rr_last),
    .o_grant (w_grant),
    .o_id    (w_id)
  );

  assign w_accept    = |w_grant;
  assign w_sel_we    = req_we[w_id];
  assign w_sel_addr  = req_addr[w_id*ADDR_W +: ADDR_W];
  assign w_sel_wdata = req_wdata[w_id*DATA_W +: DATA_W];
  assign w_sel_wstrb = req_wstrb[w_id*STRB_W +: STRB_W];

  always_comb begin
    w_tag_in              = '0;
    w_tag_in.valid        = w_accept;
    w_tag_in.id[ID_W-1:0] = w_id;
    w_tag_in.is_read      = ~w_sel_we;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
      r_rr_last   <= ID_W'(NUM_REQ - 1);
      r_grant_id  <= '0;
      r_tag       <= '0;
    end else begin
      r_bram_en <= w_accept;
      r_bram_we <= (w_accept && w_sel_we) ? w_sel_wstrb : '0;
      r_tag     <= {r_tag[RD_LAT-1:0], w_tag_in};
      if (w_accept) begin
        r_bram_addr <= w_sel_addr & ADDR_MASK;
        r_bram_din  <= w_sel_wdata;
        r_rr_last   <= w_id;
        r_grant_id  <= w_id;
      end
    end
  end

  // Oldest stage lines up with the cycle the BRAM presents read data.
  assign w_tag_out = r_tag[RD_LAT];

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = w_tag_out.valid && (w_tag_out.id == TAG_ID_W'(i));
    end
  end

  assign rsp_rdata = (w_tag_out.valid && w_tag_out.is_read) ? bram_dout : '0;
  assign req_ready = w_grant;
  assign grant_id  = r_grant_id;
  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter: a 2-requester RD_LAT=1 instance with a
// BRAM model, plus a 4-requester RD_LAT=3 instance driven by a random sweep.
module tb_bram_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: NUM_REQ=2, RD_LAT=1
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] rsp_rdata, bram_addr, bram_din, bram_dout;
  logic [0:0]  grant_id;
  logic        bram_en;
  logic [3:0]  bram_we;

  // Instance 1: NUM_REQ=4, RD_LAT=3
  logic [3:0]   req_valid1, req_ready1, req_we1, rsp_valid1;
  logic [127:0] req_addr1, req_wdata1;
  logic [15:0]  req_wstrb1;
  logic [31:0]  rsp_rdata1, bram_addr1, bram_din1, bram_dout1;
  logic [1:0]   grant_id1;
  logic         bram_en1;
  logic [3:0]   bram_we1;

  bram_rr_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut0 (
    .ACLK(clk), .ARESETn(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .grant_id(grant_id), .bram_en(bram_en),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  bram_rr_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut1 (
    .ACLK(clk), .ARESETn(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .grant_id(grant_id1), .bram_en(bram_en1),
    .bram_we(bram_we1), .bram_addr(bram_addr1), .bram_din(bram_din1), .bram_dout(bram_dout1)
  );

  // BRAM model for instance 0: one-cycle read latency, byte-write enables
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr[9:2]][b*8 +: 8] <= bram_din[b*8 +: 8];
      end
      bram_dout <= mem[bram_addr[9:2]];
    end
  end

  // Instance 1 BRAM returns the issued address three cycles later
  logic [31:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= bram_addr1;
    p2 <= p1;
    p3 <= p2;
  end
  assign bram_dout1 = p3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
  endtask

  task automatic idle1();
    req_valid1 = '0; req_we1 = '0; req_addr1 = '0; req_wdata1 = '0; req_wstrb1 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle0();
    idle1();
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if ({req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, grant_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b rsp=%b rdata=%h en=%b we=%h gid=%h, required all 0",
               req_ready, rsp_valid, rsp_rdata, bram_en, bram_we, grant_id);
    end
    n_tests++;
    if ({bram_addr, bram_din} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h din=%h, required 0", bram_addr, bram_din);
    end
    n_tests++;
    if ({req_ready1, rsp_valid1, bram_en1, grant_id1} !== '0) begin
      n_fail++;
      $display("FAIL reset_inst1: got rdy=%b rsp=%b en=%b gid=%h, required 0",
               req_ready1, rsp_valid1, bram_en1, grant_id1);
    end
    rst_n = 1'b1;
    req_valid = 2'b01;
    req_addr[31:0] = 32'h0000_0103;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL first_grant: got ready=%b, required 01", req_ready);
    end
    tick();
    idle0();
    n_tests++;
    if (bram_en !== 1'b1 || bram_addr !== 32'h0000_0100 || bram_we !== 4'h0) begin
      n_fail++;
      $display("FAIL first_issue: got en=%b addr=%h we=%h, required 1/00000100/0",
               bram_en, bram_addr, bram_we);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL first_rsp: got rsp_valid=%b, required 01", rsp_valid);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 2'b00 || bram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL first_idle: got rsp=%b en=%b, required 00/0", rsp_valid, bram_en);
    end
  endtask

  task automatic test_write_read();
    req_valid = 2'b01; req_we = 2'b01; req_addr[31:0] = 32'hA001_0000;
    req_wdata[31:0] = 32'hDEAD_BEEF; req_wstrb[3:0] = 4'hF;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_grant: got ready=%b, required 01", req_ready);
    end
    tick();
    n_tests++;
    if (bram_en !== 1'b1 || bram_we !== 4'hF || bram_addr !== 32'hA001_0000 ||
        bram_din !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_issue: got en=%b we=%h addr=%h din=%h, required 1/f/a0010000/deadbeef",
               bram_en, bram_we, bram_addr, bram_din);
    end
    req_we = 2'b00;
    tick();
    idle0();
    n_tests++;
    if (bram_en !== 1'b1 || bram_we !== 4'h0 || rsp_valid !== 2'b01 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_rsp: got en=%b we=%h rsp=%b rdata=%h, required 1/0/01/0",
               bram_en, bram_we, rsp_valid, rsp_rdata);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rd_rsp: got rsp=%b rdata=%h, required 01/deadbeef", rsp_valid, rsp_rdata);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_rsp_end: got rsp=%b, required 00", rsp_valid);
    end
  endtask

  // Last grant so far was requester 0, so rotation starts at 1.
  task automatic test_alternate();
    logic [1:0] exp_rdy, exp_rsp;
    req_addr = {32'h0000_0020, 32'h0000_0010};
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 2'b11 : 2'b00;
      #1;
      exp_rdy = (k < 8) ? ((((k + 1) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (k >= 2) ? ((((k - 1) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
      n_tests++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL alt_grant[%0d]: got ready=%b, required %b", k, req_ready, exp_rdy);
      end
      n_tests++;
      if (rsp_valid !== exp_rsp) begin
        n_fail++;
        $display("FAIL alt_rsp[%0d]: got rsp_valid=%b, required %b", k, rsp_valid, exp_rsp);
      end
      tick();
    end
    idle0();
    n_tests++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_drain: got rsp_valid=%b, required 00", rsp_valid);
    end
  endtask

  task automatic test_byte_strobe();
    req_valid = 2'b01; req_we = 2'b01; req_addr[31:0] = 32'h0000_0040;
    req_wdata[31:0] = 32'hFFFF_FFFF; req_wstrb[3:0] = 4'hF;
    tick();
    req_wdata[31:0] = 32'h0000_0000; req_wstrb[3:0] = 4'h5;
    tick();
    n_tests++;
    if (bram_we !== 4'h5 || bram_din !== 32'h0) begin
      n_fail++;
      $display("FAIL strb_issue: got we=%h din=%h, required 5/0", bram_we, bram_din);
    end
    req_we = 2'b00;
    tick();
    idle0();
    tick();
    n_tests++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hFF00_FF00) begin
      n_fail++;
      $display("FAIL strb_readback: got rsp=%b rdata=%h, required 01/ff00ff00",
               rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req_we = 2'b00; req_addr[31:0] = 32'h0000_0040;
    repeat (3) tick();
    idle0();
    n_tests++;
    if (rsp_valid !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_inflight: got rsp_valid=%b, required 01", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rsp_valid !== 2'b00 || bram_en !== 1'b0 || bram_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_async: got rsp=%b en=%b addr=%h, required 00/0/0",
               rsp_valid, bram_en, bram_addr);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 2) rst_n = 1'b1;
      n_tests++;
      if (rsp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_norsp[%0d]: got rsp_valid=%b, required 00", k, rsp_valid);
      end
    end
    req_valid = 2'b11;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_restart: got ready=%b, required 01", req_ready);
    end
    tick();
    idle0();
    n_tests++;
    if (grant_id !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_gid: got grant_id=%0d, required 0", grant_id);
    end
    repeat (3) tick();
  endtask

  typedef struct {
    int unsigned id;
    bit          rd;
    logic [31:0] addr;
    int          due;
  } sb_t;

  task automatic test_sweep();
    sb_t         sb_q[$];
    sb_t         e;
    int          m_last = 3;
    int          m_gid  = 0;
    int          win;
    int          n_acc  = 0;
    int          n_seen = 0;
    logic [3:0]  exp_rdy, exp_rsp;
    logic [31:0] exp_rdata, a;
    for (int c = 0; c < 1010; c++) begin
      if (c < 1000) begin
        for (int i = 0; i < 4; i++) begin
          req_valid1[i] = 1'($urandom_range(0, 1));
          req_we1[i]    = 1'($urandom_range(0, 1));
          a = (32'(c) << 8) | (32'(i) << 4) | 32'($urandom_range(0, 3));
          req_addr1[i*32 +: 32]  = a;
          req_wdata1[i*32 +: 32] = $urandom;
          req_wstrb1[i*4 +: 4]   = 4'hF;
        end
      end else begin
        idle1();
      end
      #1;
      n_tests++;
      if (grant_id1 !== 2'(m_gid)) begin
        n_fail++;
        $display("FAIL sweep_gid[%0d]: got %0d, required %0d", c, grant_id1, m_gid);
      end
      win = -1;
      for (int k = 1; k <= 4; k++) begin
        if (win < 0 && req_valid1[(m_last + k) % 4]) win = (m_last + k) % 4;
      end
      exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      n_tests++;
      if (req_ready1 !== exp_rdy) begin
        n_fail++;
        $display("FAIL sweep_grant[%0d]: got ready=%b, required %b", c, req_ready1, exp_rdy);
      end
      if (win >= 0) begin
        e.id   = win;
        e.rd   = !req_we1[win];
        e.addr = req_addr1[win*32 +: 32] & 32'hFFFF_FFFC;
        e.due  = c + 4;
        sb_q.push_back(e);
        m_last = win;
        m_gid  = win;
        n_acc++;
      end
      exp_rsp   = 4'b0000;
      exp_rdata = 32'h0;
      if (sb_q.size() > 0 && sb_q[0].due == c) begin
        e         = sb_q.pop_front();
        exp_rsp   = 4'b0001 << e.id;
        exp_rdata = e.rd ? e.addr : 32'h0;
      end
      if (rsp_valid1 != 4'b0000) n_seen++;
      n_tests++;
      if (rsp_valid1 !== exp_rsp || (exp_rsp != 4'b0000 && rsp_rdata1 !== exp_rdata)) begin
        n_fail++;
        $display("FAIL sweep_rsp[%0d]: got rsp=%b rdata=%h, required %b/%h",
                 c, rsp_valid1, rsp_rdata1, exp_rsp, exp_rdata);
      end
      tick();
    end
    n_tests++;
    if (n_seen !== n_acc) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d responses, required %0d", n_seen, n_acc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_byte_strobe();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
